coeff_load_responder: RTL

// FIR-side responder to the coefficient loader's load_coeff/coefficient_num/modwait handshake.

---
 rtl/fir_coeff_pkg.sv | 19 +
 rtl/coeff_regfile.sv | 47 ++++
 rtl/coeff_load_responder.sv | 130 +++++++++++++
 3 files changed

// File: rtl/fir_coeff_pkg.sv
// Shared types and sizes for the FIR coefficient load responder.
package fir_coeff_pkg;

    localparam int unsigned COEFF_W    = 16;
    localparam int unsigned NUM_COEFFS = 4;
    localparam int unsigned IDX_W      = $clog2(NUM_COEFFS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        HOLD  = 2'd2
    } coeff_state_t;

    // Index that follows idx in load order, wrapping after the last coefficient.
    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
        next_idx = (idx == IDX_W'(NUM_COEFFS - 1)) ? '0 : idx + IDX_W'(1);
    endfunction

endpackage

// File: rtl/coeff_regfile.sv
// Coefficient store: NUM_COEFFS registers, one synchronous write port,
// one combinational read port, and the "full set loaded" tracker.
module coeff_regfile
    import fir_coeff_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = COEFF_W
) (
    input  logic                  clk,
    input  logic                  n_reset,
    input  logic                  we,
    input  logic [IDX_W-1:0]      widx,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [IDX_W-1:0]      rsel,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  coeffs_valid
);

    logic [DATA_WIDTH-1:0] regs_q [NUM_COEFFS];
    logic [NUM_COEFFS-1:0] mask_q;
    logic [NUM_COEFFS-1:0] mask_d;

    // Mask after this write: index 0 starts a new set, others add their bit.
    always_comb begin
        mask_d = mask_q | (NUM_COEFFS'(1) << widx);
        if (widx == '0) begin
            mask_d = NUM_COEFFS'(1);
        end
    end

    // Storage, mask and valid flag all update on the write edge.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            for (int i = 0; i < int'(NUM_COEFFS); i++) begin
                regs_q[i] <= '0;
            end
            mask_q       <= '0;
            coeffs_valid <= 1'b0;
        end else if (we) begin
            regs_q[widx] <= wdata;
            mask_q       <= mask_d;
            coeffs_valid <= &mask_d;
        end
    end

    assign rdata = regs_q[rsel];

endmodule

// File: rtl/coeff_load_responder.sv
// FIR-side responder to the coefficient loader handshake. Accepts one
// coefficient per load_coeff request, holds modwait for LOAD_CYCLES cycles
// and writes the value into coeff_regfile.
// Optional feature: define COEFF_ORDER_CHECK_EN to flag out-of-order indices
// on order_err; otherwise order_err is tied low.
module coeff_load_responder
    import fir_coeff_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = COEFF_W,
    parameter int unsigned LOAD_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  n_reset,
    input  logic                  load_coeff,
    input  logic [IDX_W-1:0]      coefficient_num,
    input  logic [DATA_WIDTH-1:0] coeff_data,
    input  logic [IDX_W-1:0]      coeff_sel,
    output logic                  modwait,
    output logic [DATA_WIDTH-1:0] coeff_out,
    output logic                  coeffs_valid,
    output logic                  order_err
);

    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] HOLD_INIT =
        (LOAD_CYCLES > 1) ? CNT_W'(LOAD_CYCLES - 2) : '0;

    coeff_state_t          state_q, state_d;
    logic [CNT_W-1:0]      hold_cnt_q, hold_cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  modwait_d;
    logic                  accept_c;
    logic                  we_c;

    assign accept_c = (state_q == IDLE) && load_coeff;
    assign we_c     = (state_q == WRITE);

    // Next-state, hold counter, latched request and busy flag.
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        idx_d      = idx_q;
        data_d     = data_q;
        modwait_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept_c) begin
                    state_d   = WRITE;
                    idx_d     = coefficient_num;
                    data_d    = coeff_data;
                    modwait_d = 1'b1;
                end
            end
            WRITE: begin
                if (LOAD_CYCLES == 1) begin
                    state_d = IDLE;
                end else begin
                    state_d    = HOLD;
                    hold_cnt_d = HOLD_INIT;
                    modwait_d  = 1'b1;
                end
            end
            HOLD: begin
                if (hold_cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    hold_cnt_d = hold_cnt_q - CNT_W'(1);
                    modwait_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register; modwait is its own flop so it is glitch-free.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q    <= IDLE;
            hold_cnt_q <= '0;
            idx_q      <= '0;
            data_q     <= '0;
            modwait    <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            idx_q      <= idx_d;
            data_q     <= data_d;
            modwait    <= modwait_d;
        end
    end

`ifdef COEFF_ORDER_CHECK_EN
    logic [IDX_W-1:0] expected_q;
    logic             order_err_q;

    // Track the expected index; index 0 always starts a new set without error.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            expected_q  <= '0;
            order_err_q <= 1'b0;
        end else if (accept_c) begin
            expected_q  <= next_idx(coefficient_num);
            order_err_q <= (coefficient_num != '0) && (coefficient_num != expected_q);
        end else begin
            order_err_q <= 1'b0;
        end
    end

    assign order_err = order_err_q;
`else
    assign order_err = 1'b0;
`endif

    coeff_regfile #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_regfile (
        .clk          (clk),
        .n_reset      (n_reset),
        .we           (we_c),
        .widx         (idx_q),
        .wdata        (data_q),
        .rsel         (coeff_sel),
        .rdata        (coeff_out),
        .coeffs_valid (coeffs_valid)
    );

endmodule
